button_ctrl_fsm: RTL and testbench

//  Upstream control stage of the button press counter. Turns four raw, bouncing,

---
 rtl/button_counter_pkg.sv | 38 +++
 rtl/button_debouncer.sv | 57 +++++
 rtl/button_ctrl_fsm.sv | 130 +++++++++++++
 tb/tb_button_ctrl_fsm.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_counter_pkg.sv
// Purpose: shared definitions for the button press counter (ctrl codes, button indices, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   CTRL_WIDTH / CTRL_*  command codes driven on ctrl toward the counter register
//   BTN_*                bit positions of each button inside the 4-bit button vectors
//   ctrl_state_t         repeat-control FSM states
//   max_int              constant helper used for sizing the repeat timer
package button_counter_pkg;

  localparam int CTRL_WIDTH = 3;

  localparam logic [CTRL_WIDTH-1:0] CTRL_NONE = 3'd0;
  localparam logic [CTRL_WIDTH-1:0] CTRL_CLR  = 3'd1;
  localparam logic [CTRL_WIDTH-1:0] CTRL_LOAD = 3'd2;
  localparam logic [CTRL_WIDTH-1:0] CTRL_INCR = 3'd3;
  localparam logic [CTRL_WIDTH-1:0] CTRL_DECR = 3'd4;

  // Button vector layout {clr, load, incr, decr}; the same order is used
  // for btn_state so the status LEDs line up with the panel.
  localparam int NUM_BTN  = 4;
  localparam int BTN_CLR  = 3;
  localparam int BTN_LOAD = 2;
  localparam int BTN_INCR = 1;
  localparam int BTN_DECR = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Purpose: 2-flop synchronizer, counter debouncer and press-edge pulse for one raw push-button.
// Latency: debounced level changes DEBOUNCE_CYCLES+2 edges after a stable raw change; rise is registered with it.
// Backpressure: none; rise is a one-cycle pulse that must be consumed when seen.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active-low
//   btn    in   raw asynchronous button, 1 = pressed
//   level  out  debounced button level
//   rise   out  one-cycle pulse in the cycle after level went 0->1
module button_debouncer
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The counter measures how long the synchronized input has disagreed with
  // the debounced level; any agreement restarts the count, so a glitch
  // shorter than DEBOUNCE_CYCLES never reaches the flip point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        // Only the press direction produces an event; releases are silent.
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_ctrl_fsm.sv
// Purpose: turns four bouncing push-buttons into one-cycle NONE/CLR/LOAD/INCR/DECR commands with auto-repeat.
// Latency: raw press held -> ctrl on edge DEBOUNCE_CYCLES+3; ctrl is registered.
// Backpressure: none; the counter register must accept ctrl every cycle, and losing same-cycle presses are dropped.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active-low
//   btn_clr    in   1  raw button, async, 1 = pressed
//   btn_load   in   1  raw button, async, 1 = pressed
//   btn_incr   in   1  raw button, async, 1 = pressed
//   btn_decr   in   1  raw button, async, 1 = pressed
//   ctrl       out  3  command to counter register, non-NONE for one cycle per event
//   btn_state  out  4  debounced levels {clr,load,incr,decr}
module button_ctrl_fsm
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_clr,
  input  logic                  btn_load,
  input  logic                  btn_incr,
  input  logic                  btn_decr,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [NUM_BTN-1:0]    btn_state
);

  localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  // The timer counts down to zero and the expiry is acted on in the cycle it
  // reads zero, so loading N-1 gives exactly N cycles between emissions.
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0]    raw;
  logic [NUM_BTN-1:0]    lvl;
  logic [NUM_BTN-1:0]    rise;
  logic [CTRL_WIDTH-1:0] evt_code;
  logic                  is_dir_evt;
  logic                  held_lvl;
  logic [CTRL_WIDTH-1:0] dir_code;

  ctrl_state_t           state;
  logic                  dir_decr;
  logic [TW-1:0]         timer;

  assign raw = {btn_clr, btn_load, btn_incr, btn_decr};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (raw[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  // Debounced levels are already registered inside the debouncers.
  assign btn_state = lvl;

  // Fixed-priority pick among same-cycle press events.
  always_comb begin
    evt_code = CTRL_NONE;
    if (rise[BTN_CLR]) begin
      evt_code = CTRL_CLR;
    end else if (rise[BTN_LOAD]) begin
      evt_code = CTRL_LOAD;
    end else if (rise[BTN_INCR]) begin
      evt_code = CTRL_INCR;
    end else if (rise[BTN_DECR]) begin
      evt_code = CTRL_DECR;
    end
  end

  assign is_dir_evt = (evt_code == CTRL_INCR) || (evt_code == CTRL_DECR);
  assign held_lvl   = dir_decr ? lvl[BTN_DECR] : lvl[BTN_INCR];
  assign dir_code   = dir_decr ? CTRL_DECR : CTRL_INCR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ctrl     <= CTRL_NONE;
      dir_decr <= 1'b0;
      timer    <= '0;
    end else begin
      ctrl <= CTRL_NONE;
      case (state)
        ST_IDLE: begin
          ctrl <= evt_code;
          if (REPEAT_EN && is_dir_evt) begin
            state    <= ST_HOLD;
            dir_decr <= (evt_code == CTRL_DECR);
            timer    <= DELAY_LOAD;
          end
        end

        ST_HOLD, ST_REPEAT: begin
          // CLR/LOAD presses win over everything while a direction is held;
          // presses of the other direction are deliberately ignored here.
          if (rise[BTN_CLR]) begin
            ctrl  <= CTRL_CLR;
            state <= ST_IDLE;
          end else if (rise[BTN_LOAD]) begin
            ctrl  <= CTRL_LOAD;
            state <= ST_IDLE;
          end else if (!held_lvl) begin
            state <= ST_IDLE;
          end else if (timer == '0) begin
            ctrl  <= dir_code;
            state <= ST_REPEAT;
            timer <= PERIOD_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_ctrl_fsm.sv
module tb_button_ctrl_fsm;
  import button_counter_pkg::*;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_clr, btn_load, btn_incr, btn_decr;
  logic [2:0] ctrl;
  logic [3:0] btn_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_ctrl_fsm #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_EN      (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_clr   (btn_clr),
    .btn_load  (btn_load),
    .btn_incr  (btn_incr),
    .btn_decr  (btn_decr),
    .ctrl      (ctrl),
    .btn_state (btn_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_clr, btn_load, btn_incr, btn_decr} = m;
  endtask

  // Leaves the bench #1 after a clock edge with reset released: call that edge 0.
  task automatic do_reset();
    rst = 1'b0;
    set_btns(4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- table-driven single presses ----------------
  typedef struct {
    logic [3:0] btns;
    int         hold;
    logic [2:0] exp_code;
    int         exp_edge;
    int         exp_count;
    logic [3:0] exp_state;  // debounced levels after edge 8
  } vec_t;

  vec_t vecs[7];

  task automatic run_table();
    int first_edge, cnt;
    logic [2:0] first_code;
    logic [3:0] st8;
    vecs[0] = '{4'b0010, 5, CTRL_INCR, 7, 1, 4'b0010};
    vecs[1] = '{4'b0101, 5, CTRL_LOAD, 7, 1, 4'b0101};
    vecs[2] = '{4'b1000, 5, CTRL_CLR,  7, 1, 4'b1000};
    vecs[3] = '{4'b0010, 3, CTRL_NONE, -1, 0, 4'b0000};
    vecs[4] = '{4'b1111, 5, CTRL_CLR,  7, 1, 4'b1111};
    vecs[5] = '{4'b0011, 5, CTRL_INCR, 7, 1, 4'b0011};
    vecs[6] = '{4'b0001, 4, CTRL_DECR, 7, 1, 4'b0001};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      first_edge = -1;
      first_code = CTRL_NONE;
      cnt = 0;
      st8 = 4'b0000;
      set_btns(vecs[v].btns);
      for (int e = 1; e <= 40; e++) begin
        tick();
        if (e == vecs[v].hold) set_btns(4'b0000);
        if (e == 8) st8 = btn_state;
        if (ctrl != CTRL_NONE) begin
          cnt++;
          if (first_edge < 0) begin
            first_edge = e;
            first_code = ctrl;
          end
        end
      end
      check($sformatf("vec%0d code", v), 32'(first_code), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d edge", v), first_edge, vecs[v].exp_edge);
      check($sformatf("vec%0d count", v), cnt, vecs[v].exp_count);
      check($sformatf("vec%0d btn_state", v), 32'(st8), 32'(vecs[v].exp_state));
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Sync = raw seen two edges late; the debounced level follows the synced
  // value once it has disagreed for DB straight edges. Repeats are placed by
  // arithmetic on the age since the first emission of a held direction.
  bit m_s1[4], m_s2[4], m_lvl[4], m_press[4];
  int m_streak[4];
  bit m_held;
  int m_dir;     // button index of the held direction
  int m_t0;
  int m_edge;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0; m_streak[b] = 0;
    end
    m_held = 0; m_dir = 0; m_t0 = 0; m_edge = 0;
  endtask

  function automatic logic [3:0] model_levels();
    return {m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0]};
  endfunction

  task automatic model_edge(input logic [3:0] r, output int code);
    int age;
    bit np[4];
    m_edge++;
    code = 0;
    if (m_held) begin
      if (m_press[3]) begin
        code = 1; m_held = 0;
      end else if (m_press[2]) begin
        code = 2; m_held = 0;
      end else if (!m_lvl[m_dir]) begin
        m_held = 0;
      end else begin
        age = m_edge - m_t0;
        if (age == RD || (age > RD && (age - RD) % RP == 0)) code = 4 - m_dir;
      end
    end else begin
      for (int b = 3; b >= 0; b--) begin
        if (m_press[b] && code == 0) begin
          code = 4 - b;
          if (b <= 1) begin
            m_held = 1; m_dir = b; m_t0 = m_edge;
          end
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      np[b] = 0;
      if (m_s2[b] != m_lvl[b]) m_streak[b]++;
      else m_streak[b] = 0;
      if (m_streak[b] == DB) begin
        m_lvl[b] = m_s2[b];
        np[b] = m_s2[b];
        m_streak[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = r[b];
      m_press[b] = np[b];
    end
  endtask

  task automatic run_random();
    logic [3:0] cur;
    int code;
    do_reset();
    model_reset();
    cur = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        #1;
        check("rand reset ctrl", 32'(ctrl), 0);
        check("rand reset btn_state", 32'(btn_state), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
      set_btns(cur);
      tick();
      model_edge(cur, code);
      check($sformatf("rand c%0d ctrl", c), 32'(ctrl), code);
      check($sformatf("rand c%0d btn_state", c), 32'(btn_state), 32'(model_levels()));
    end
  endtask

  // ---------------- hand-written multi-cycle sequences ----------------
  initial begin
    int q_got[$];
    int q_exp[$];
    int n1, n3, n_other, e1, n3_after;
    logic [2:0] c;

    rst = 1'b0;
    set_btns(4'b1111);
    #12;
    check("reset ctrl", 32'(ctrl), 0);
    check("reset btn_state", 32'(btn_state), 0);

    run_table();

    // Bouncing clr: 1,0,1,0 for two samples each, then steady 1.
    do_reset();
    n1 = 0; n_other = 0; e1 = -1;
    for (int e = 1; e <= 30; e++) begin
      btn_clr = (e <= 2) || (e >= 5 && e <= 6) || (e >= 9);
      tick();
      if (ctrl == CTRL_CLR) begin n1++; e1 = e; end
      else if (ctrl != CTRL_NONE) n_other++;
    end
    check("bounce clr count", n1, 1);
    check("bounce clr edge", e1, 9 + DB + 2);
    check("bounce other cmds", n_other, 0);
    check("bounce btn_state", 32'(btn_state), 32'(4'b1000));

    // Held decr with auto-repeat, released after 30 samples.
    do_reset();
    q_got.delete();
    q_exp.delete();
    q_exp.push_back(DB + 3);
    for (int t = DB + 3 + RD; t < 30 + DB + 3; t += RP) q_exp.push_back(t);
    n_other = 0;
    set_btns(4'b0001);
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (e == 30) set_btns(4'b0000);
      if (ctrl == CTRL_DECR) q_got.push_back(e);
      else if (ctrl != CTRL_NONE) n_other++;
    end
    check("repeat decr count", q_got.size(), q_exp.size());
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++)
      check($sformatf("repeat decr edge[%0d]", i), q_got[i], q_exp[i]);
    check("repeat decr other cmds", n_other, 0);

    // Clr pressed while incr is repeating: clr preempts, repeats stop.
    do_reset();
    n1 = 0; n3 = 0; n3_after = 0; e1 = -1;
    set_btns(4'b0010);
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (e == 16) set_btns(4'b1010);
      c = ctrl;
      if (c == CTRL_CLR) begin n1++; e1 = e; end
      if (c == CTRL_INCR) begin
        if (e1 < 0) n3++;
        else n3_after++;
      end
    end
    check("preempt clr count", n1, 1);
    check("preempt clr edge", e1, 16 + DB + 3);
    check("preempt incr before", n3, 4);
    check("preempt incr after", n3_after, 0);

    // Reset pulsed while incr repeats; button stays held through it.
    do_reset();
    set_btns(4'b0010);
    for (int e = 1; e <= 18; e++) tick();
    check("mid-repeat ctrl before reset", 32'(ctrl), 32'(CTRL_INCR));
    rst = 1'b0;
    #1;
    check("mid-repeat reset ctrl", 32'(ctrl), 0);
    check("mid-repeat reset btn_state", 32'(btn_state), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q_got.delete();
    q_exp.delete();
    q_exp.push_back(DB + 3);
    for (int t = DB + 3 + RD; t <= 30; t += RP) q_exp.push_back(t);
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (ctrl != CTRL_NONE) q_got.push_back(e);
    end
    check("post-reset incr count", q_got.size(), q_exp.size());
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++)
      check($sformatf("post-reset incr edge[%0d]", i), q_got[i], q_exp[i]);

    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
